// File: rtl/mac_accumulate_if.sv
// Stream bundle between the MAC stage, its beat producer and the requantization consumer.
// The master modport is the producer/consumer side; the slave modport is the MAC stage.
interface mac_accumulate_if #(
    parameter int INT32_SIZE = 32,
    parameter int LANES      = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*8-1:0]           in_input;
    logic [LANES*8-1:0]           in_filter;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [INT32_SIZE-1:0] out_acc;

    modport master (
        output in_valid, in_input, in_filter, in_last, out_ready,
        input  in_ready, out_valid, out_acc
    );

    modport slave (
        input  in_valid, in_input, in_filter, in_last, out_ready,
        output in_ready, out_valid, out_acc
    );
endinterface

// File: rtl/mac_accumulate.sv
// Pipelined int8 multiply-accumulate: offset-adjusted lane products registered in S1,
// folded into a packet accumulator, and handed off through a one-entry output register.
module mac_accumulate #(
    parameter int INT32_SIZE = 32,
    parameter int LANES      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [INT32_SIZE-1:0] input_offset,
    mac_accumulate_if.slave              bus,
    output logic [15:0]                  beat_count,
    output logic                         busy
);

    function automatic logic signed [INT32_SIZE-1:0] sext8(input logic [7:0] v);
        return {{(INT32_SIZE-8){v[7]}}, v};
    endfunction

    logic signed [INT32_SIZE-1:0] w_prod [LANES];
    logic signed [INT32_SIZE-1:0] w_sum;
    logic                         w_accept;
    logic                         w_s1_consume;
    logic                         w_last_consume;
    logic                         w_out_take;

    logic signed [INT32_SIZE-1:0] r_s1_prod [LANES];
    logic                         r_s1_valid;
    logic                         r_s1_last;
    logic signed [INT32_SIZE-1:0] r_acc;
    logic [15:0]                  r_beat_count;
    logic                         r_out_valid;
    logic signed [INT32_SIZE-1:0] r_out_acc;

    // Products wrap to INT32_SIZE bits; no saturation anywhere in the datapath.
    always_comb begin : lane_products
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = (sext8(bus.in_input[8*i +: 8]) + input_offset)
                        * sext8(bus.in_filter[8*i +: 8]);
        end
    end

    always_comb begin : lane_sum
        // NOTE: default assignment first so no path through always_comb infers a latch.
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + r_s1_prod[i];
        end
    end

    // Only a last beat can stall, and only while an unaccepted result occupies the output.
    assign w_s1_consume   = r_s1_valid && (!r_s1_last || !r_out_valid || bus.out_ready);
    assign w_last_consume = w_s1_consume && r_s1_last;
    assign w_out_take     = r_out_valid && bus.out_ready;
    assign bus.in_ready   = !r_s1_valid || w_s1_consume;
    assign w_accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin : s1_control
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= bus.in_last;
        end else if (w_s1_consume) begin
            r_s1_valid <= 1'b0;
        end
    end

    // NOTE: product registers carry no reset; r_s1_valid qualifies every use of them.
    always_ff @(posedge clk) begin : s1_data
        if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= w_prod[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin : accumulate
        if (reset) begin
            r_acc        <= '0;
            r_beat_count <= '0;
            r_out_valid  <= 1'b0;
            r_out_acc    <= '0;
        end else begin
            if (w_s1_consume) begin
                if (r_s1_last) begin
                    r_out_acc    <= r_acc + w_sum;
                    r_out_valid  <= 1'b1;
                    r_acc        <= '0;
                    r_beat_count <= '0;
                end else begin
                    r_acc <= r_acc + w_sum;
                    if (r_beat_count != 16'hFFFF) begin
                        r_beat_count <= r_beat_count + 16'd1;
                    end
                end
            end
            // A drain coinciding with a new result keeps the register full: no bubble.
            if (w_out_take && !w_last_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_acc   = r_out_acc;
    assign beat_count    = r_beat_count;
    assign busy          = r_s1_valid || (r_beat_count != 16'd0) || r_out_valid;

endmodule

// File: tb/tb_mac_accumulate.sv
// Self-checking bench for mac_accumulate: constant-table packets, directed corner sequences,
// and a randomized stream checked in order against a scoreboard fed by an independent model.
module tb_mac_accumulate;

    logic               clk;
    logic               reset;
    logic signed [31:0] input_offset;
    logic [15:0]        beat_count;
    logic               busy;

    mac_accumulate_if #(.INT32_SIZE(32), .LANES(4)) bus ();

    mac_accumulate #(.INT32_SIZE(32), .LANES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_offset (input_offset),
        .bus          (bus),
        .beat_count   (beat_count),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] off;
        logic [31:0] x;
        logic [31:0] f;
        logic [31:0] req;
    } vec_t;

    vec_t        vecs [7];
    int          checks   = 0;
    int          failures = 0;
    int          m_acc    = 0;
    int          n_push   = 0;
    int          n_out    = 0;
    bit          rand_ready = 0;
    logic [31:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(req), req);
        end
    endtask

    function automatic int model_sum(input int off, input logic [31:0] x, input logic [31:0] f);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            s += (int'($signed(x[8*i +: 8])) + off) * int'($signed(f[8*i +: 8]));
        end
        return s;
    endfunction

    // Entered at a falling edge; returns at the falling edge after the beat was accepted.
    task automatic send_beat(input logic [31:0] x, input logic [31:0] f, input bit last);
        bit done   = 0;
        int budget = 0;
        int s;
        bus.in_valid  = 1'b1;
        bus.in_input  = x;
        bus.in_filter = f;
        bus.in_last   = last;
        while (!done) begin
            #1;
            if (bus.in_ready) begin
                s = model_sum(int'(input_offset), x, f);
                if (last) begin
                    exp_q.push_back(m_acc + s);
                    n_push++;
                    m_acc = 0;
                end else begin
                    m_acc += s;
                end
                done = 1;
            end else if (budget++ > 2000) begin
                check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
                done = 1;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Waits for a presented result and compares it against a bench-supplied constant.
    task automatic wait_out(input string name, input logic [31:0] req);
        int budget = 0;
        #1;
        while (!bus.out_valid && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check(name, bus.out_acc, req);
        @(negedge clk);
    endtask

    initial begin : scoreboard
        forever begin
            @(negedge clk);
            #1;
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("scoreboard", bus.out_acc, exp_q.pop_front());
                end
                n_out++;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : main
        vecs[0] = '{32'd0,         32'h04030201, 32'h01010101, 32'd10};
        vecs[1] = '{32'd128,       32'hFFFFFFFF, 32'h81818181, -32'd64516};
        vecs[2] = '{32'd128,       32'h80808080, 32'h7F7F7F7F, 32'd0};
        vecs[3] = '{32'h7FFFFF80,  32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFFE04};
        vecs[4] = '{32'hFFFFFFFF,  32'h04030201, 32'h02020202, 32'd12};
        vecs[5] = '{32'd0,         32'h80808080, 32'h80808080, 32'd65536};
        vecs[6] = '{32'd0,         32'h7F80FF01, 32'h02FF7F80, 32'd127};

        reset         = 1'b1;
        input_offset  = '0;
        bus.in_valid  = 1'b0;
        bus.in_input  = '0;
        bus.in_filter = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_acc",    bus.out_acc,            32'd0);
        check("rst_beat_count", {16'd0, beat_count},    32'd0);
        check("rst_busy",       {31'd0, busy},          32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-beat sum packet with latency and beat counting.
        bus.out_ready = 1'b1;
        send_beat(32'h04030201, 32'h01010101, 1'b0);
        send_beat(32'h04030201, 32'h01010101, 1'b1);
        idle();
        check("sum_beat_count_mid", {16'd0, beat_count},    32'd1);
        check("sum_not_yet_valid",  {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("sum_out_valid",      {31'd0, bus.out_valid}, 32'd1);
        check("sum_out_acc",        bus.out_acc,            32'd20);
        check("sum_beat_count_end", {16'd0, beat_count},    32'd0);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            input_offset = vecs[i].off;
            send_beat(vecs[i].x, vecs[i].f, 1'b1);
            idle();
            wait_out($sformatf("table%0d", i), vecs[i].req);
        end
        input_offset = '0;
        @(negedge clk);

        // Backpressure: A (1 beat, 10) then B (2 beats, 20) with the output blocked.
        bus.out_ready = 1'b0;
        send_beat(32'h04030201, 32'h01010101, 1'b1);
        send_beat(32'h04030201, 32'h01010101, 1'b0);
        send_beat(32'h04030201, 32'h01010101, 1'b1);
        idle();
        repeat (3) begin
            check("bp_in_ready_low", {31'd0, bus.in_ready},  32'd0);
            check("bp_out_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_acc_hold", bus.out_acc,            32'd10);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_out_valid_after", {31'd0, bus.out_valid}, 32'd1);
        check("bp_out_acc_b",       bus.out_acc,            32'd20);
        check("bp_in_ready_back",   {31'd0, bus.in_ready},  32'd1);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of an open packet.
        for (int i = 0; i < 3; i++) send_beat($urandom, $urandom, 1'b0);
        idle();
        reset = 1'b1;
        m_acc = 0;
        #1;
        check("mid_rst_in_ready",   {31'd0, bus.in_ready},  32'd1);
        check("mid_rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_beat_count", {16'd0, beat_count},    32'd0);
        check("mid_rst_busy",       {31'd0, busy},          32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_beat(32'h04030201, 32'h01010101, 1'b1);
        idle();
        wait_out("post_rst_packet", 32'd10);

        // Random stream with random output backpressure.
        input_offset = $urandom;
        rand_ready   = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int len;
            len = $urandom_range(1, 64);
            for (int b = 0; b < len; b++) begin
                send_beat($urandom, $urandom, b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    @(negedge clk);
                end
            end
        end
        idle();
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        check("stream_output_count", 32'(n_out), 32'(n_push));
        check("stream_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
